// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one line-wide memory bus among NUM_MASTERS requesters.
// Define MEM_BUS_ARB_TIMEOUT_EN to build the BUSY watchdog (TIMEOUT_CYCLES).
module mem_bus_arbiter #(
  parameter int BUS_ADDRESS_WIDTH    = 20,
  parameter int BUS_DATA_WIDTH_SHIFT = 4,
  parameter int NUM_MASTERS          = 2,
  parameter int TIMEOUT_CYCLES       = 1023
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic [NUM_MASTERS-1:0] m_req_i,
  input  logic [NUM_MASTERS-1:0] m_we_i,
  input  logic [NUM_MASTERS*(BUS_ADDRESS_WIDTH-BUS_DATA_WIDTH_SHIFT)-1:0] m_addr_i,
  input  logic [NUM_MASTERS*(2**BUS_DATA_WIDTH_SHIFT)*8-1:0] m_data_i,
  output logic [NUM_MASTERS-1:0] m_grant_o,
  output logic [NUM_MASTERS-1:0] m_valid_o,
  output logic m_err_o,
  output logic [(2**BUS_DATA_WIDTH_SHIFT)*8-1:0] m_data_o,
  output logic bus_req_o,
  output logic [BUS_ADDRESS_WIDTH-BUS_DATA_WIDTH_SHIFT-1:0] bus_addr_o,
  output logic [(2**BUS_DATA_WIDTH_SHIFT)*8-1:0] bus_data_o,
  output logic bus_we_o,
  input  logic [(2**BUS_DATA_WIDTH_SHIFT)*8-1:0] bus_data_i,
  input  logic bus_valid_i
);

  localparam int LW = BUS_ADDRESS_WIDTH - BUS_DATA_WIDTH_SHIFT;
  localparam int DW = (2**BUS_DATA_WIDTH_SHIFT) * 8;
  localparam int N  = NUM_MASTERS;
  localparam int IW = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] win;
  logic [IW-1:0] pick;
  logic found;
  logic any_req;
  logic timeout;
  int idx;

  assign any_req = |m_req_i;

  // First requester at or after ptr, wrapping modulo N.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && m_req_i[idx[IW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IW-1:0];
      end
    end
  end

`ifdef MEM_BUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign timeout = (state == BUSY) &&
                   (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      ptr        <= '0;
      win        <= '0;
      m_grant_o  <= '0;
      m_valid_o  <= '0;
      m_err_o    <= 1'b0;
      m_data_o   <= '0;
      bus_req_o  <= 1'b0;
      bus_addr_o <= '0;
      bus_data_o <= '0;
      bus_we_o   <= 1'b0;
`ifdef MEM_BUS_ARB_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state      <= BUSY;
            win        <= pick;
            ptr        <= (int'(pick) == N - 1) ? '0 : pick + 1'b1;
            m_grant_o  <= '0;
            m_grant_o[pick] <= 1'b1;
            bus_req_o  <= 1'b1;
            bus_we_o   <= m_we_i[pick];
            bus_addr_o <= m_addr_i[int'(pick)*LW +: LW];
            bus_data_o <= m_data_i[int'(pick)*DW +: DW];
`ifdef MEM_BUS_ARB_TIMEOUT_EN
            cnt        <= '0;
`endif
          end
        end
        BUSY: begin
          // A real completion beats a timeout landing in the same cycle.
          if (bus_valid_i || timeout) begin
            state     <= DONE;
            bus_req_o <= 1'b0;
            m_valid_o <= '0;
            m_valid_o[win] <= 1'b1;
            m_err_o   <= !bus_valid_i;
            m_data_o  <= bus_valid_i ? bus_data_i : '0;
          end
`ifdef MEM_BUS_ARB_TIMEOUT_EN
          else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          state     <= IDLE;
          m_valid_o <= '0;
          m_err_o   <= 1'b0;
          m_grant_o <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed cases plus randomized rounds
// checked against a round-robin reference model and a bus responder.
module tb_mem_bus_arbiter;

  localparam int N  = 3;
  localparam int LW = 16;
  localparam int DW = 128;

  logic clk = 1'b0;
  logic rst_i;
  logic [N-1:0] m_req_i, m_we_i;
  logic [N*LW-1:0] m_addr_i;
  logic [N*DW-1:0] m_data_i;
  logic [N-1:0] m_grant_o, m_valid_o;
  logic m_err_o;
  logic [DW-1:0] m_data_o;
  logic bus_req_o, bus_we_o;
  logic [LW-1:0] bus_addr_o;
  logic [DW-1:0] bus_data_o;
  logic [DW-1:0] bus_data_i;
  logic bus_valid_i;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .BUS_ADDRESS_WIDTH(20),
    .BUS_DATA_WIDTH_SHIFT(4),
    .NUM_MASTERS(N),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .m_req_i(m_req_i),
    .m_we_i(m_we_i),
    .m_addr_i(m_addr_i),
    .m_data_i(m_data_i),
    .m_grant_o(m_grant_o),
    .m_valid_o(m_valid_o),
    .m_err_o(m_err_o),
    .m_data_o(m_data_o),
    .bus_req_o(bus_req_o),
    .bus_addr_o(bus_addr_o),
    .bus_data_o(bus_data_o),
    .bus_we_o(bus_we_o),
    .bus_data_i(bus_data_i),
    .bus_valid_i(bus_valid_i)
  );

  typedef struct {
    int idx;
    logic we;
    logic [LW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic err;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_err = 0;
  int mptr = 0;
  logic mon_en = 1'b0;

  // responder controls: -1 random latency, -2 never respond, else fixed
  int bus_lat = 0;
  logic stray_en = 1'b0;
  logic rd_ovr_en = 1'b0;
  logic [DW-1:0] rd_ovr = '0;
  int wait_left = 0;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] fdat(input logic [LW-1:0] a);
    return {4{a, a ^ 16'hA5C3}};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] mask, input int p);
    for (int i = 0; i < N; i++)
      if (mask[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  // Reference: serve held requests in round-robin order from mptr.
  task automatic push_round(input logic [N-1:0] mask);
    logic [N-1:0] rem;
    exp_t e;
    int j;
    rem = mask;
    while (rem != 0) begin
      j = rr_pick(rem, mptr);
      mptr = (j + 1) % N;
      e.idx = j;
      e.we = m_we_i[j];
      e.addr = m_addr_i[j*LW +: LW];
      e.wdata = m_data_i[j*DW +: DW];
      e.rdata = rd_ovr_en ? rd_ovr : fdat(e.addr);
      e.err = 1'b0;
      q.push_back(e);
      rem[j] = 1'b0;
    end
  endtask

  task automatic set_m(input int k, input logic we, input logic [LW-1:0] a,
                       input logic [DW-1:0] d);
    m_we_i[k] = we;
    m_addr_i[k*LW +: LW] = a;
    m_data_i[k*DW +: DW] = d;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((m_req_i != 0 || q.size() != 0) && t < 300) begin
      @(negedge clk);
      m_req_i &= ~m_valid_o;
      t++;
    end
    if (t >= 300) begin
      check("drain_timeout_req", m_req_i, 0);
      check("drain_timeout_q", q.size(), 0);
    end
    @(negedge clk);
  endtask

  // bus responder
  always @(negedge clk) begin
    if (bus_req_o) begin
      if (wait_left == 0 && bus_lat != -2) begin
        bus_valid_i = 1'b1;
        bus_data_i = rd_ovr_en ? rd_ovr : fdat(bus_addr_o);
      end else begin
        bus_valid_i = 1'b0;
        bus_data_i = {$urandom, $urandom, $urandom, $urandom};
        if (wait_left > 0) wait_left--;
      end
    end else begin
      bus_valid_i = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
      bus_data_i = {$urandom, $urandom, $urandom, $urandom};
      wait_left = (bus_lat == -1) ? $urandom_range(0, 4) :
                  (bus_lat < 0) ? 0 : bus_lat;
    end
  end

  // monitor
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (bus_req_o && !prev_req) begin
        if (q.size() == 0) check("unexpected_grant", bus_req_o, 0);
        else begin
          check("grant", m_grant_o, 1 << q[0].idx);
          check("bus_we", bus_we_o, q[0].we);
          check("bus_addr", bus_addr_o, q[0].addr);
          check("bus_data", bus_data_o, q[0].wdata);
        end
      end else if (bus_req_o && q.size() != 0) begin
        check("addr_hold", bus_addr_o, q[0].addr);
        check("data_hold", bus_data_o, q[0].wdata);
      end
      if (m_valid_o != 0) begin
        if (q.size() == 0) check("unexpected_valid", m_valid_o, 0);
        else begin
          e = q.pop_front();
          check("valid", m_valid_o, 1 << e.idx);
          check("done_grant", m_grant_o, 1 << e.idx);
          check("err", m_err_o, e.err);
          if (!e.we || e.err) check("rdata", m_data_o, e.rdata);
        end
      end
    end
    prev_req = bus_req_o;
  end

  initial begin
    int busy;
    int rem[N];
    int rises, last, cyc;
    logic pr;
    logic [N-1:0] mask;
    rst_i = 1'b1;
    bus_valid_i = 1'b0;
    bus_data_i = '0;
    m_req_i = '0;
    m_we_i = '0;
    m_addr_i = '0;
    m_data_i = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_grant", m_grant_o, 0);
    check("rst_valid", m_valid_o, 0);
    check("rst_err", m_err_o, 0);
    check("rst_mdata", m_data_o, 0);
    check("rst_busreq", bus_req_o, 0);
    check("rst_busaddr", bus_addr_o, 0);
    check("rst_busdata", bus_data_o, 0);
    check("rst_buswe", bus_we_o, 0);
    rst_i = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // single read, minimum latency
    rd_ovr_en = 1'b1;
    rd_ovr = {4{32'hDEADBEEF}};
    set_m(0, 1'b0, 16'h1234, '0);
    push_round(3'b001);
    m_req_i = 3'b001;
    @(negedge clk);
    check("t1_busreq_c1", bus_req_o, 1);
    @(negedge clk);
    check("t1_valid_c2", m_valid_o, 3'b001);
    check("t1_mdata", m_data_o, {4{32'hDEADBEEF}});
    m_req_i = '0;
    @(negedge clk);
    rd_ovr_en = 1'b0;

    // write with 5-cycle stall, stray valids, payload change mid-BUSY
    stray_en = 1'b1;
    bus_lat = 5;
    set_m(1, 1'b1, 16'h0ABC, {16{8'h55}});
    push_round(3'b010);
    m_req_i = 3'b010;
    busy = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus_req_o) busy++;
      if (busy == 3) m_addr_i[1*LW +: LW] = 16'hFFFF;
      if (m_valid_o != 0) break;
    end
    check("t2_valid", m_valid_o, 3'b010);
    check("t2_busy_cycles", busy, 6);
    check("t2_addr_latched", bus_addr_o, 16'h0ABC);
    m_req_i = '0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      check("stray_idle", m_valid_o, 0);
    end

    // fairness with all three requesting
    stray_en = 1'b0;
    bus_lat = 0;
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    mptr = 0;
    for (int k = 0; k < N; k++)
      set_m(k, 1'(k % 2), 16'(16'h0100 + k), {8{16'(k + 1)}});
    push_round(3'b111);
    push_round(3'b001);
    rem = '{2, 1, 1};
    rises = 0;
    last = 0;
    cyc = 0;
    pr = 1'b0;
    m_req_i = 3'b111;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      cyc++;
      if (bus_req_o && !pr) begin
        rises++;
        if (rises > 1) check("rr_period", cyc - last, 3);
        last = cyc;
      end
      pr = bus_req_o;
      for (int k = 0; k < N; k++) begin
        if (m_valid_o[k]) begin
          rem[k]--;
          m_req_i[k] = 1'b0;
        end else m_req_i[k] = (rem[k] > 0);
      end
      if (rem[0] + rem[1] + rem[2] == 0) break;
    end
    check("rr_rises", rises, 4);
    drain();

    // randomized rounds
    bus_lat = -1;
    stray_en = 1'b1;
    for (int r = 0; r < 30; r++) begin
      mask = 3'($urandom_range(1, 7));
      for (int k = 0; k < N; k++)
        set_m(k, 1'($urandom_range(0, 1)), 16'($urandom),
              {$urandom, $urandom, $urandom, $urandom});
      push_round(mask);
      m_req_i = mask;
      drain();
    end

    // asynchronous reset mid-BUSY
    mon_en = 1'b0;
    stray_en = 1'b0;
    bus_lat = -2;
    set_m(2, 1'b0, 16'h7777, '0);
    m_req_i = 3'b100;
    @(negedge clk);
    @(negedge clk);
    check("rst_pre_busy", bus_req_o, 1);
    #2 rst_i = 1'b1;
    #1;
    check("rst_async_busreq", bus_req_o, 0);
    check("rst_async_grant", m_grant_o, 0);
    m_req_i = '0;
    @(negedge clk);
    rst_i = 1'b0;
    mptr = 0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check("rst_no_valid", m_valid_o, 0);
    end
    mon_en = 1'b1;
    bus_lat = 0;
    set_m(0, 1'b0, 16'h0010, '0);
    set_m(1, 1'b1, 16'h0020, {4{32'h0BADF00D}});
    push_round(3'b011);
    m_req_i = 3'b011;
    @(negedge clk);
    check("rst_first_winner", m_grant_o, 3'b001);
    drain();

`ifdef MEM_BUS_ARB_TIMEOUT_EN
    begin
      exp_t e;
      bus_lat = -2;
      set_m(0, 1'b0, 16'h0300, '0);
      push_round(3'b001);
      e = q.pop_back();
      e.err = 1'b1;
      e.rdata = '0;
      q.push_back(e);
      m_req_i = 3'b001;
      busy = 0;
      for (int t = 0; t < 40; t++) begin
        @(negedge clk);
        if (bus_req_o) busy++;
        if (m_valid_o != 0) break;
      end
      check("to_busy_cycles", busy, 8);
      check("to_err", m_err_o, 1);
      m_req_i = '0;
      @(negedge clk);
      @(negedge clk);
      bus_lat = 7;
      push_round(3'b001);
      m_req_i = 3'b001;
      busy = 0;
      for (int t = 0; t < 40; t++) begin
        @(negedge clk);
        if (bus_req_o) busy++;
        if (m_valid_o != 0) break;
      end
      check("to_race_busy", busy, 8);
      check("to_race_err", m_err_o, 0);
      m_req_i = '0;
      @(negedge clk);
      @(negedge clk);
    end
`endif

    check("final_queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Round-robin arbiter that shares the single external line-wide memory bus among `NUM_MASTERS` requesters, such as the instruction cache, the data cache and a DMA. It supports both reads and writes, so the CPU top no longer ties `bus_we_o` to 0. It sits between the caches and the bus pins in the CPU top. It latches one request at a time, drives it on the bus until `bus_valid_i`, then returns the response to the granted master.

## Interface
Parameters:
- `BUS_ADDRESS_WIDTH`, default 20: byte address width of the memory bus.
- `BUS_DATA_WIDTH_SHIFT`, default 4: log2 of bus bytes; `BUS_DATA_WIDTH = 2**SHIFT*8` (128 bits).
- `NUM_MASTERS`, default 2: number of requesters, legal range 2..8.
- `TIMEOUT_CYCLES`, default 1023: watchdog limit; used only under the macro in Configuration.

Ports (`LW = BUS_ADDRESS_WIDTH - BUS_DATA_WIDTH_SHIFT`, `DW = BUS_DATA_WIDTH`, `N = NUM_MASTERS`):
- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `m_req_i`  in  N  per-master request level.
- `m_we_i`  in  N  per-master write enable (1 = write line).
- `m_addr_i`  in  N*LW  packed line addresses; master k at `[k*LW +: LW]`.
- `m_data_i`  in  N*DW  packed write data.
- `m_grant_o`  out  N  one-hot; the master currently owning the bus.
- `m_valid_o`  out  N  one-hot, 1-cycle completion strobe.
- `m_err_o`  out  1  qualifies `m_valid_o` as a timeout abort.
- `m_data_o`  out  DW  read data; shared by all masters.
- `bus_req_o`  out  1  transaction active on the bus.
- `bus_addr_o`  out  LW  line address.
- `bus_data_o`  out  DW  write data.
- `bus_we_o`  out  1  write enable.
- `bus_data_i`  in  DW  read data.
- `bus_valid_i`  in  1  bus completion; meaningful only while `bus_req_o` = 1.

## Operation
- FSM states and transitions:
  - IDLE → BUSY when any `m_req_i` is set.
  - BUSY → DONE on `bus_valid_i` (or timeout).
  - DONE → IDLE unconditionally.
- Arbitration in IDLE uses a round-robin pointer `ptr` of width `$clog2(N)`.
  - The winner is the first requester at or after `ptr`, wrapping modulo N.
  - On grant, `ptr` ← winner+1; this wraps to 0 when the winner is N-1.
- On entering BUSY, the winner's `we`, `addr` and `data` are latched. Bus outputs are driven only from the latched copy, so later master input changes have no effect.
- DONE behaviour:
  - `m_valid_o[winner]` = 1 for exactly one cycle.
  - `m_data_o` holds the `bus_data_i` registered on the completing edge; its value is don't-care for writes.
  - No arbitration takes place in DONE.
- Masters must hold `m_req_i` and payload stable until `m_valid_o`, and deassert `m_req_i` by the edge that ends DONE.
- `bus_valid_i` is ignored in IDLE and DONE.
- `m_req_i` bits are ignored in BUSY; simultaneous new requests wait.
- Reset values: state IDLE, `ptr` 0, and all outputs 0, including `m_data_o`, `bus_addr_o`, `bus_data_o` and `m_grant_o`.
- Reset asserted mid-transaction:
  - `bus_req_o` and `m_grant_o` drop immediately.
  - No `m_valid_o` is issued, and the transaction is lost.

## Timing
- All outputs are registered.
- A request seen at edge E gives `m_grant_o`, `bus_req_o` and the bus payload valid from E+1.
- If `bus_valid_i` = 1 in the first BUSY cycle, `m_valid_o` is asserted in cycle E+2. This is the minimum latency, 2 cycles.
- Back-to-back transactions cost 1 IDLE cycle between DONE and the next BUSY. Peak throughput is 1 line per 3 cycles.
- `m_grant_o` is high through BUSY and DONE and clears on entering IDLE.

## Configuration
- `MEM_BUS_ARB_TIMEOUT_EN` defined:
  - A counter, cleared on entering BUSY, increments each BUSY cycle.
  - When the count reaches `TIMEOUT_CYCLES` without `bus_valid_i`, the FSM goes to DONE with `m_err_o` = 1 and `m_data_o` = 0.
  - If `bus_valid_i` and the timeout fire in the same cycle, `bus_valid_i` wins and `m_err_o` = 0.
- Macro undefined:
  - No counter is built, and `m_err_o` is tied to 0.
  - BUSY waits indefinitely for `bus_valid_i`.

## Test plan
- Reset, then idle: all outputs 0. A single read from master 0 at addr 0x1234 with `bus_valid_i` in the first BUSY cycle and `bus_data_i` = 0xDEADBEEF… → `bus_req_o` in cycle 1, `m_valid_o` = 0b01 in cycle 2, `m_data_o` equal to the driven data.
- Master 1 write, addr 0x0ABC, data 0x55…55 → `bus_we_o` = 1, `bus_addr_o` = 0x0ABC and `bus_data_o` = 0x55…55 held stable for a 5-cycle bus stall; then `m_valid_o` = 0b10.
- Fairness, `N` = 3, all three requesting continuously → grant order 0, 1, 2, 0; exactly 3 cycles per grant with immediate `bus_valid_i`.
- Stray `bus_valid_i` in IDLE and a master changing `m_addr_i` during BUSY → no `m_valid_o`; `bus_addr_o` unchanged.
- Asynchronous `rst_i` pulse mid-BUSY (between clock edges) → `bus_req_o` and `m_grant_o` go to 0 before the next edge; no `m_valid_o`; after release, master 0 wins first.
- With `MEM_BUS_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 8, and no `bus_valid_i` → DONE after 8 BUSY cycles with `m_err_o` = 1 and `m_data_o` = 0. Also drive `bus_valid_i` in cycle 8 → `m_err_o` = 0.
